switch_allocator: RTL
=====================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter VC_NUM, default noc_params VC_NUM; number of virtual channels per input port.
REQ-002 SHALL have parameter PORT_NUM, default noc_params PORT_NUM (5); number of router ports, indexed identically for input and output.
REQ-003 SHALL derive VC_SIZE = $clog2(VC_NUM) and PORT_SIZE = $clog2(PORT_NUM).
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 request_i  input  [PORT_NUM][VC_NUM]  switch request per input port/VC, from input-port sa_request_o.
REQ-007 out_port_i  input  port_t [PORT_NUM][VC_NUM]  routed output port per input VC.
REQ-008 downstream_vc_i  input  [PORT_NUM][VC_NUM] x VC_SIZE  allocated downstream VC per input VC.
REQ-009 on_off_i  input  [PORT_NUM][VC_NUM]  per output port, per downstream VC: 1 = downstream buffer accepts a flit.
REQ-010 valid_o  output  [PORT_NUM]  per input port: grant this cycle; drives input-port sa_valid_i.
REQ-011 vc_sel_o  output  [PORT_NUM] x VC_SIZE  per input port: granted VC; drives sa_sel_vc_i.
REQ-012 xb_sel_o  output  [PORT_NUM] x PORT_SIZE  per output port: granted input port; crossbar select.
REQ-013 xb_valid_o  output  [PORT_NUM]  per output port: crossbar carries a valid flit.
REQ-014 xb_vc_o  output  [PORT_NUM] x VC_SIZE  per output port: downstream VC id of the forwarded flit.

Function
REQ-015 An input VC SHALL be eligible iff request_i=1 and on_off_i[out_port_i][downstream_vc_i]=1.
REQ-016 Stage 1: per input port, a round-robin arbiter SHALL pick one eligible VC, starting the search at in_ptr[p].
REQ-017 Stage 2: per output port, a round-robin arbiter SHALL pick one input port among those whose stage-1 winner targets it, starting the search at out_ptr[o].
REQ-018 Grants SHALL be combinational from current inputs and pointers: zero-cycle latency, request to valid_o in the same cycle.
REQ-019 At most one grant per input port and at most one per output port SHALL be issued per cycle.
REQ-020 For a stage-2 winner p on output o: valid_o[p]=1, vc_sel_o[p]=stage-1 VC, xb_valid_o[o]=1, xb_sel_o[o]=p, xb_vc_o[o]=downstream_vc_i[p][vc].
REQ-021 Ungranted outputs SHALL read valid_o=0, vc_sel_o=0, xb_valid_o=0, xb_sel_o=0, xb_vc_o=0.
REQ-022 On a stage-2 grant, out_ptr[o] SHALL update to (p+1) mod PORT_NUM at next posedge.
REQ-023 in_ptr[p] SHALL update to (vc+1) mod VC_NUM only if its stage-1 winner also won stage 2; a stage-1 winner that loses stage 2 SHALL leave in_ptr[p] unchanged.
REQ-024 Pointers SHALL hold when no grant is made.
REQ-025 Pointer increment SHALL wrap from VC_NUM-1 to 0 and from PORT_NUM-1 to 0.
REQ-026 A VC whose downstream on_off drops SHALL not be granted in that cycle, even if it holds priority.
REQ-027 A request whose out_port_i is not a legal port index SHALL be treated as ineligible.

Reset
REQ-028 rst=1 SHALL asynchronously clear all in_ptr and out_ptr to 0.
REQ-029 While rst=1, all outputs SHALL be forced to 0 regardless of inputs.
REQ-030 rst asserted mid-operation SHALL suppress grants in that cycle; arbitration after deassertion SHALL start from index 0.

Verification
REQ-031 Single request: port 0 VC1 to port 2, downstream VC 0 on -> valid_o[0]=1, vc_sel_o[0]=1, xb_sel_o[2]=0, xb_vc_o[2]=0, same cycle.
REQ-032 Output conflict: ports 1 and 3 both request output 4 every cycle, pointers reset -> grants alternate 1,3,1,3; never both in one cycle.
REQ-033 VC fairness: port 2, VC0 and VC1 both request distinct free outputs continuously -> vc_sel_o[2] alternates 0,1,0; in_ptr wraps to 0.
REQ-034 Flow control: on_off_i[1][0]=0 with port 0 VC0 requesting output 1 VC0 -> no grant; set on_off to 1 -> grant same cycle.
REQ-035 Stage-2 loss: port 0 loses output 4 to port 1 -> in_ptr[0] unchanged next cycle; port 0 VC0 retains priority.
REQ-036 Reset mid-run: assert rst during contention -> all outputs 0 immediately; after release, lowest-index requester wins first.

Source files
------------

// File: rtl/switch_allocator.sv
// ============================================================================
// switch_allocator
// ----------------------------------------------------------------------------
// Separable input-first switch allocator for a NoC router. It makes its grants
// combinationally, in the same cycle as the requests.
//   Stage 1: each input port round-robins over its eligible VCs.
//   Stage 2: each output port round-robins over the input ports whose
//            stage-1 winner targets it.
// An input VC is eligible only if all of these hold:
//   - it requests;
//   - its routed output port is a legal index;
//   - the downstream VC it was allocated currently signals on (credit available).
// Each input port has a VC pointer and each output port has a port pointer.
// These pointers advance only on an end-to-end grant.
//
// Ports
//   clk              clock, state on posedge
//   rst              asynchronous active-high reset (also blanks all outputs)
//   request_i        [port][vc] switch request
//   out_port_i       [port][vc] routed output port
//   downstream_vc_i  [port][vc] allocated downstream VC
//   on_off_i         [out port][downstream vc] downstream buffer ready
//   valid_o          [in port]  grant this cycle
//   vc_sel_o         [in port]  granted VC
//   xb_sel_o         [out port] granted input port (crossbar select)
//   xb_valid_o       [out port] crossbar carries a valid flit
//   xb_vc_o          [out port] downstream VC of the forwarded flit
// ============================================================================
module switch_allocator #(
    parameter int VC_NUM    = 2,
    parameter int PORT_NUM  = 5,
    localparam int VC_SIZE   = $clog2(VC_NUM),
    localparam int PORT_SIZE = $clog2(PORT_NUM)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                     request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]      out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]        downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                     on_off_i,
    output logic [PORT_NUM-1:0]                                 valid_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]                    vc_sel_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]                  xb_sel_o,
    output logic [PORT_NUM-1:0]                                 xb_valid_o,
    output logic [PORT_NUM-1:0][VC_SIZE-1:0]                    xb_vc_o
);

    logic [VC_SIZE-1:0]              in_ptr_reg   [PORT_NUM];
    logic [VC_SIZE-1:0]              in_ptr_next  [PORT_NUM];
    logic [PORT_SIZE-1:0]            out_ptr_reg  [PORT_NUM];
    logic [PORT_SIZE-1:0]            out_ptr_next [PORT_NUM];

    logic [PORT_NUM-1:0][VC_NUM-1:0] eligible;

    // Stage-1 results, indexed by input port
    logic [PORT_NUM-1:0]             s1_valid;
    logic [VC_SIZE-1:0]              s1_vc   [PORT_NUM];
    logic [PORT_SIZE-1:0]            s1_port [PORT_NUM];

    // Stage-2 results, indexed by output port
    logic [PORT_NUM-1:0]             s2_valid;
    logic [PORT_SIZE-1:0]            s2_port [PORT_NUM];
    logic [VC_SIZE-1:0]              s2_vc   [PORT_NUM];

    // End-to-end grant, indexed by input port
    logic [PORT_NUM-1:0]             granted;

    genvar gi, gj;

    // ------------------------------------------------------------------------
    // Eligibility. Illegal output-port codes are masked before they can index
    // on_off_i.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_elig_port
            for (gj = 0; gj < VC_NUM; gj++) begin : g_elig_vc
                logic [PORT_SIZE-1:0] op;
                logic [VC_SIZE-1:0]   dv;
                logic                 legal;
                assign op    = out_port_i[gi][gj];
                assign dv    = downstream_vc_i[gi][gj];
                assign legal = (int'(op) < PORT_NUM);
                assign eligible[gi][gj] = request_i[gi][gj] && legal && on_off_i[op][dv];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 1: per input port, search the VCs starting at in_ptr.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage1
            logic               found;
            logic [VC_SIZE-1:0] vc;

            always_comb begin
                int idx;
                idx   = 0;
                found = 1'b0;
                vc    = '0;
                for (int k = 0; k < VC_NUM; k++) begin
                    idx = (int'(in_ptr_reg[gi]) + k) % VC_NUM;
                    if (!found && eligible[gi][idx]) begin
                        found = 1'b1;
                        vc    = VC_SIZE'(idx);
                    end
                end
            end

            assign s1_valid[gi]    = found;
            assign s1_vc[gi]       = vc;
            assign s1_port[gi]     = out_port_i[gi][vc];
            assign in_ptr_next[gi] = VC_SIZE'((int'(vc) + 1) % VC_NUM);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 2: per output port, search the input ports starting at out_ptr.
    // Only the stage-1 winners compete.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_stage2
            logic                 found;
            logic [PORT_SIZE-1:0] sel;

            always_comb begin
                int idx;
                idx   = 0;
                found = 1'b0;
                sel   = '0;
                for (int k = 0; k < PORT_NUM; k++) begin
                    idx = (int'(out_ptr_reg[gi]) + k) % PORT_NUM;
                    if (!found && s1_valid[idx] && (s1_port[idx] == PORT_SIZE'(gi))) begin
                        found = 1'b1;
                        sel   = PORT_SIZE'(idx);
                    end
                end
            end

            assign s2_valid[gi]     = found;
            assign s2_port[gi]      = sel;
            assign s2_vc[gi]        = downstream_vc_i[sel][s1_vc[sel]];
            assign out_ptr_next[gi] = PORT_SIZE'((int'(sel) + 1) % PORT_NUM);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // An input is granted when its stage-1 winner also won at its target
    // output. s1_valid guarantees that s1_port is a legal index here.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_grant
            assign granted[gi] = s1_valid[gi] && s2_valid[s1_port[gi]]
                                 && (s2_port[s1_port[gi]] == PORT_SIZE'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs are blanked while reset is held so that no grant leaks during
    // the asynchronous reset window.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_out
            logic in_gnt;
            logic out_gnt;
            assign in_gnt  = !rst && granted[gi];
            assign out_gnt = !rst && s2_valid[gi];

            assign valid_o[gi]    = in_gnt;
            assign vc_sel_o[gi]   = in_gnt  ? s1_vc[gi]   : '0;
            assign xb_valid_o[gi] = out_gnt;
            assign xb_sel_o[gi]   = out_gnt ? s2_port[gi] : '0;
            assign xb_vc_o[gi]    = out_gnt ? s2_vc[gi]   : '0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pointer state. in_ptr advances only on an end-to-end grant, so a VC that
    // loses at stage 2 keeps its priority for the next cycle.
    // ------------------------------------------------------------------------
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_ptr
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ptr_reg[gi]  <= '0;
                    out_ptr_reg[gi] <= '0;
                end else begin
                    if (granted[gi]) begin
                        in_ptr_reg[gi] <= in_ptr_next[gi];
                    end
                    if (s2_valid[gi]) begin
                        out_ptr_reg[gi] <= out_ptr_next[gi];
                    end
                end
            end
        end
    endgenerate

endmodule
